frame_writer: RTL and testbench
===============================

// Module: frame_writer
// PURPOSE
//  Downstream sink of the ray-trace renderer's pixel stream. Accepts 24-bit pixels plus hcount/vcount sideband
//  and packs them to RGB565. Writes them into a double-buffered BRAM frame buffer.
//  After the last pixel of a frame it requests a bank swap and stalls the renderer until display logic acks at vsync.
// PARAMETERS
//  H_RES   320  active pixels per line; hcount >= H_RES is out of frame
//  V_RES   180  active lines per frame; vcount >= V_RES is out of frame
//  ADDR_W  16   frame-buffer address width; must satisfy 2**ADDR_W >= H_RES*V_RES
// PORTS
//  aclk              in   1       clock
//  aresetn           in   1       asynchronous reset, active low
//  pixel_axis_tdata  in   24      {R[23:16],G[15:8],B[7:0]}
//  pixel_axis_tvalid in   1       pixel valid; qualifies hcount_in/vcount_in
//  pixel_axis_tready out  1       sink ready
//  hcount_in         in   11      pixel column, sampled on handshake
//  vcount_in         in   10      pixel row, sampled on handshake
//  fb_wr_en          out  1       BRAM write strobe
//  fb_wr_bank        out  1       bank selected for this write
//  fb_wr_addr        out  ADDR_W  vcount*H_RES + hcount
//  fb_wr_data        out  16      RGB565 {R[7:3],G[7:2],B[7:3]}
//  display_bank      out  1       bank display logic must read
//  swap_req          out  1       level: a frame is complete and waiting for swap
//  swap_ack          in   1       display logic (vsync domain, already synchronised) grants swap
//  frame_done        out  1       one-cycle pulse when a swap completes
//  frame_count       out  16      completed frames, wraps 0xFFFF->0
//  drop_count        out  16      out-of-range pixels discarded, saturates at 0xFFFF
// BEHAVIOUR
//  - Reset (aresetn=0, async): state=WRITE; write bank=0; display_bank=1.
//    fb_wr_en, swap_req, frame_done, frame_count, drop_count, fb_wr_addr and fb_wr_data are all 0.
//  - Handshake = tvalid & tready. pixel_axis_tready = (state==WRITE), registered. It never depends on tvalid.
//  - Latency: handshake in cycle N gives fb_wr_en=1 in cycle N+1, with addr/data/bank registered together.
//    fb_wr_en=0 on every other cycle.
//  - In-range test: hcount_in<H_RES && vcount_in<V_RES. If out of range, there is no write and drop_count+1 (saturating).
//  - Address: hcount + vcount*H_RES, computed in ADDR_W+1 bits and truncated. A constant multiply is allowed.
//  - Last pixel: handshake with hcount=H_RES-1, vcount=V_RES-1 writes normally. state->SWAP_WAIT.
//    swap_req=1 from N+1, and tready=0 from N+1.
//  - SWAP_WAIT: tready=0; swap_req held. swap_ack=1 sampled in SWAP_WAIT ends the wait. In the next cycle:
//    display_bank<=write bank, write bank toggles, frame_count+1, frame_done=1 for one cycle,
//    swap_req=0, state->WRITE.
//  - An ack in cycle N+1 (same cycle as the last write) is legal. That write still uses the old bank.
//  - swap_ack while in WRITE is ignored. Pixels arriving in WRITE after a drop are unaffected.
//  - Pixels are not required in raster order. A duplicate coordinate rewrites that address.
//    A frame ends only at the last-pixel coordinate.
//  - No reset mid-frame recovery beyond the reset values. Upstream must also be reset.
// STRUCTURE
//  - Shared package fb_pkg holds:
//    - FB_H_RES/FB_V_RES default constants;
//    - typedef enum logic {WRITE, SWAP_WAIT} fw_state_t;
//    - function rgb888_to_565.
//  - No sub-module: one FSM, one output register stage, two counters.
// TESTING
//  - Reset: hold aresetn=0 with tvalid=1 -> tready=0, fb_wr_en=0, display_bank=1. After release, tready=1 and counts are 0.
//  - Single pixel h=5,v=2,data=0xFF8040 -> next cycle fb_wr_en=1, addr=645, data=0xFC08, bank=0.
//  - Out of range h=320,v=0 -> no fb_wr_en; drop_count=1. 70000 drops -> drop_count stays 0xFFFF.
//  - Full raster 320x180 -> 57600 writes, addr 0..57599, swap_req=1 after the last write.
//    tvalid held high with no ack for 100 cycles -> tready=0, no writes.
//  - swap_ack pulse -> frame_done one cycle, display_bank=0, frame_count=1.
//    The next frame is written to bank 1.
//  - swap_ack in the same cycle as the last write -> last write uses bank 0; swap completes next cycle.
//    swap_ack while in WRITE -> no effect.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared frame-buffer types and constants for the renderer's pixel sink.
package fb_pkg;

    localparam int unsigned FB_H_RES  = 320;
    localparam int unsigned FB_V_RES  = 180;
    localparam int unsigned FB_ADDR_W = 16;

    typedef enum logic {
        WRITE,
        SWAP_WAIT
    } fw_state_t;

    // Keep the top bits of each channel: {R[7:3], G[7:2], B[7:3]}.
    function automatic logic [15:0] rgb888_to_565(input logic [23:0] pix);
        return {pix[23:19], pix[15:10], pix[7:3]};
    endfunction

endpackage

// File: rtl/frame_writer.sv
// Packs the renderer's RGB888 stream to RGB565 and writes it into a double-buffered
// frame buffer, stalling the renderer at frame end until display logic grants the swap.
module frame_writer
    import fb_pkg::*;
#(
    parameter int unsigned H_RES  = FB_H_RES,
    parameter int unsigned V_RES  = FB_V_RES,
    parameter int unsigned ADDR_W = FB_ADDR_W
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [23:0]       pixel_axis_tdata,
    input  logic              pixel_axis_tvalid,
    output logic              pixel_axis_tready,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    output logic              fb_wr_en,
    output logic              fb_wr_bank,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [15:0]       fb_wr_data,
    output logic              display_bank,
    output logic              swap_req,
    input  logic              swap_ack,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic [15:0]       drop_count
);

    localparam int unsigned AW1 = ADDR_W + 1;

    fw_state_t      state;
    fw_state_t      state_d;
    logic           hs_c;
    logic           in_range_c;
    logic           last_c;
    logic           swap_c;
    logic [AW1-1:0] addr_full_c;
    logic           wr_bank;

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_d     = state;
        swap_c      = 1'b0;
        hs_c        = pixel_axis_tvalid & pixel_axis_tready;
        in_range_c  = (32'(hcount_in) < H_RES) && (32'(vcount_in) < V_RES);
        last_c      = hs_c && (32'(hcount_in) == H_RES - 1) && (32'(vcount_in) == V_RES - 1);
        addr_full_c = AW1'(hcount_in) + AW1'(vcount_in) * AW1'(H_RES);
        case (state)
            WRITE: begin
                if (last_c) begin
                    state_d = SWAP_WAIT;
                end
            end
            SWAP_WAIT: begin
                if (swap_ack) begin
                    swap_c  = 1'b1;
                    state_d = WRITE;
                end
            end
            default: state_d = WRITE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= WRITE;
        end else begin
            state <= state_d;
        end
    end

    // Output stage: tready/swap_req track the next state so they change with it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pixel_axis_tready <= 1'b0;
            swap_req          <= 1'b0;
            frame_done        <= 1'b0;
            fb_wr_en          <= 1'b0;
            fb_wr_bank        <= 1'b0;
            fb_wr_addr        <= '0;
            fb_wr_data        <= '0;
            wr_bank           <= 1'b0;
            display_bank      <= 1'b1;
            frame_count       <= '0;
            drop_count        <= '0;
        end else begin
            pixel_axis_tready <= (state_d == WRITE);
            swap_req          <= (state_d == SWAP_WAIT);
            frame_done        <= swap_c;
            fb_wr_en          <= hs_c && in_range_c;
            if (hs_c && in_range_c) begin
                fb_wr_addr <= ADDR_W'(addr_full_c);
                fb_wr_data <= rgb888_to_565(pixel_axis_tdata);
                fb_wr_bank <= wr_bank;
            end
            if (hs_c && !in_range_c && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
            // A write in the same cycle as the swap already captured the old bank.
            if (swap_c) begin
                display_bank <= wr_bank;
                wr_bank      <= ~wr_bank;
                frame_count  <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer: reset, packing/addressing, drops, frame swap handshake.
module tb_frame_writer;

    localparam int unsigned H_RES  = 320;
    localparam int unsigned V_RES  = 8;
    localparam int unsigned ADDR_W = 16;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [23:0]       pixel_axis_tdata;
    logic              pixel_axis_tvalid;
    logic              pixel_axis_tready;
    logic [10:0]       hcount_in;
    logic [9:0]        vcount_in;
    logic              fb_wr_en;
    logic              fb_wr_bank;
    logic [ADDR_W-1:0] fb_wr_addr;
    logic [15:0]       fb_wr_data;
    logic              display_bank;
    logic              swap_req;
    logic              swap_ack;
    logic              frame_done;
    logic [15:0]       frame_count;
    logic [15:0]       drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    int writes_seen = 0;
    int w0;

    frame_writer #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .pixel_axis_tdata  (pixel_axis_tdata),
        .pixel_axis_tvalid (pixel_axis_tvalid),
        .pixel_axis_tready (pixel_axis_tready),
        .hcount_in         (hcount_in),
        .vcount_in         (vcount_in),
        .fb_wr_en          (fb_wr_en),
        .fb_wr_bank        (fb_wr_bank),
        .fb_wr_addr        (fb_wr_addr),
        .fb_wr_data        (fb_wr_data),
        .display_bank      (display_bank),
        .swap_req          (swap_req),
        .swap_ack          (swap_ack),
        .frame_done        (frame_done),
        .frame_count       (frame_count),
        .drop_count        (drop_count)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (aresetn && fb_wr_en) writes_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input int h, input int v, input logic [23:0] d);
        pixel_axis_tvalid = 1'b1;
        hcount_in         = 11'(h);
        vcount_in         = 10'(v);
        pixel_axis_tdata  = d;
        tick();
        pixel_axis_tvalid = 1'b0;
    endtask

    // Streams a full raster back-to-back; returns right after the last write is visible.
    task automatic raster(input logic bank);
        logic [31:0] exp;
        for (int v = 0; v < int'(V_RES); v++) begin
            for (int h = 0; h < int'(H_RES); h++) begin
                pixel_axis_tvalid = 1'b1;
                hcount_in         = 11'(h);
                vcount_in         = 10'(v);
                pixel_axis_tdata  = {8'(h), 8'(v), 8'h5A};
                tick();
                exp = {14'd0, 1'b1, bank, 16'(v * 320 + h)};
                check_eq("raster_en_bank_addr", {14'd0, fb_wr_en, fb_wr_bank, fb_wr_addr}, exp);
            end
        end
        check_eq("raster_last_data", 32'(fb_wr_data), 32'h382B);
    endtask

    initial begin
        aresetn           = 1'b0;
        pixel_axis_tvalid = 1'b1;
        pixel_axis_tdata  = 24'hFF8040;
        hcount_in         = 11'd5;
        vcount_in         = 10'd2;
        swap_ack          = 1'b0;

        repeat (3) tick();
        check_eq("rst_tready", 32'(pixel_axis_tready), 32'd0);
        check_eq("rst_wr_en", 32'(fb_wr_en), 32'd0);
        check_eq("rst_display_bank", 32'(display_bank), 32'd1);
        check_eq("rst_swap_req", 32'(swap_req), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        check_eq("rst_frame_count", 32'(frame_count), 32'd0);
        check_eq("rst_drop_count", 32'(drop_count), 32'd0);
        check_eq("rst_addr", 32'(fb_wr_addr), 32'd0);
        check_eq("rst_data", 32'(fb_wr_data), 32'd0);

        pixel_axis_tvalid = 1'b0;
        aresetn           = 1'b1;
        tick();
        check_eq("post_rst_tready", 32'(pixel_axis_tready), 32'd1);
        check_eq("post_rst_counts", {frame_count, drop_count}, 32'd0);
        check_eq("post_rst_wr_en", 32'(fb_wr_en), 32'd0);

        // Single in-range pixel
        send(5, 2, 24'hFF8040);
        check_eq("px_wr_en", 32'(fb_wr_en), 32'd1);
        check_eq("px_addr", 32'(fb_wr_addr), 32'd645);
        check_eq("px_data", 32'(fb_wr_data), 32'hFC08);
        check_eq("px_bank", 32'(fb_wr_bank), 32'd0);
        tick();
        check_eq("px_wr_en_drop", 32'(fb_wr_en), 32'd0);

        // Out-of-range pixels
        send(320, 0, 24'h123456);
        check_eq("drop_h_wr_en", 32'(fb_wr_en), 32'd0);
        check_eq("drop_h_count", 32'(drop_count), 32'd1);
        send(0, 180, 24'h123456);
        check_eq("drop_v_wr_en", 32'(fb_wr_en), 32'd0);
        check_eq("drop_v_count", 32'(drop_count), 32'd2);
        send(2047, 1023, 24'h123456);
        check_eq("drop_max_count", 32'(drop_count), 32'd3);
        send(319, 0, 24'h0000FF);
        check_eq("after_drop_wr_en", 32'(fb_wr_en), 32'd1);
        check_eq("after_drop_addr", 32'(fb_wr_addr), 32'd319);
        check_eq("after_drop_data", 32'(fb_wr_data), 32'h001F);
        check_eq("after_drop_count", 32'(drop_count), 32'd3);
        tick();

        // Frame 1 into bank 0, then stall without ack
        w0 = writes_seen;
        raster(1'b0);
        check_eq("f1_swap_req", 32'(swap_req), 32'd1);
        check_eq("f1_tready", 32'(pixel_axis_tready), 32'd0);
        pixel_axis_tvalid = 1'b1;
        hcount_in         = 11'd0;
        vcount_in         = 10'd0;
        repeat (100) tick();
        check_eq("stall_tready", 32'(pixel_axis_tready), 32'd0);
        check_eq("stall_swap_req", 32'(swap_req), 32'd1);
        check_eq("stall_writes", 32'(writes_seen - w0), 32'd2560);
        check_eq("stall_frame_count", 32'(frame_count), 32'd0);
        check_eq("stall_display_bank", 32'(display_bank), 32'd1);

        swap_ack = 1'b1;
        tick();
        swap_ack          = 1'b0;
        pixel_axis_tvalid = 1'b0;
        check_eq("swap1_frame_done", 32'(frame_done), 32'd1);
        check_eq("swap1_display_bank", 32'(display_bank), 32'd0);
        check_eq("swap1_frame_count", 32'(frame_count), 32'd1);
        check_eq("swap1_swap_req", 32'(swap_req), 32'd0);
        check_eq("swap1_tready", 32'(pixel_axis_tready), 32'd1);
        check_eq("swap1_wr_en", 32'(fb_wr_en), 32'd0);
        tick();
        check_eq("swap1_done_pulse", 32'(frame_done), 32'd0);

        // Ack while writing is ignored
        swap_ack = 1'b1;
        repeat (3) tick();
        swap_ack = 1'b0;
        check_eq("ack_write_frame_count", 32'(frame_count), 32'd1);
        check_eq("ack_write_display_bank", 32'(display_bank), 32'd0);
        check_eq("ack_write_frame_done", 32'(frame_done), 32'd0);
        check_eq("ack_write_tready", 32'(pixel_axis_tready), 32'd1);

        // Frame 2 into bank 1, ack in the same cycle as the last write
        w0 = writes_seen;
        raster(1'b1);
        pixel_axis_tvalid = 1'b0;
        swap_ack          = 1'b1;
        check_eq("f2_swap_req", 32'(swap_req), 32'd1);
        tick();
        swap_ack = 1'b0;
        check_eq("swap2_frame_done", 32'(frame_done), 32'd1);
        check_eq("swap2_display_bank", 32'(display_bank), 32'd1);
        check_eq("swap2_frame_count", 32'(frame_count), 32'd2);
        check_eq("swap2_wr_en", 32'(fb_wr_en), 32'd0);
        check_eq("swap2_tready", 32'(pixel_axis_tready), 32'd1);
        tick();
        check_eq("f2_writes", 32'(writes_seen - w0), 32'd2560);

        send(1, 0, 24'h000000);
        check_eq("f3_bank", 32'(fb_wr_bank), 32'd0);
        check_eq("f3_addr", 32'(fb_wr_addr), 32'd1);
        tick();

        // Drop counter saturation
        w0 = writes_seen;
        pixel_axis_tvalid = 1'b1;
        hcount_in         = 11'd320;
        vcount_in         = 10'd0;
        repeat (100) tick();
        check_eq("drop_103", 32'(drop_count), 32'd103);
        repeat (65440) tick();
        pixel_axis_tvalid = 1'b0;
        tick();
        check_eq("drop_saturate", 32'(drop_count), 32'hFFFF);
        check_eq("drop_no_writes", 32'(writes_seen - w0), 32'd0);
        check_eq("drop_frame_count", 32'(frame_count), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
